idexe_pipe_reg: RTL and testbench

IDEXE_PIPE_REG -- requirements
Module: idexe_pipe_reg

---
 rtl/mips_pipe_pkg.sv | 41 ++++
 rtl/idexe_pipe_reg_if.sv | 55 +++++
 rtl/hazard_unit.sv | 27 ++
 rtl/idexe_pipe_reg.sv | 106 ++++++++++
 tb/tb_idexe_pipe_reg.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: default widths, ALU opcodes and the
// packed ID/EXE control bundle.
package mips_pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int ALUC_W_DEF = 4;

  localparam logic [ALUC_W_DEF-1:0] ALUC_ADD = 4'd0;
  localparam logic [ALUC_W_DEF-1:0] ALUC_SUB = 4'd1;
  localparam logic [ALUC_W_DEF-1:0] ALUC_AND = 4'd2;
  localparam logic [ALUC_W_DEF-1:0] ALUC_OR  = 4'd3;
  localparam logic [ALUC_W_DEF-1:0] ALUC_XOR = 4'd4;
  localparam logic [ALUC_W_DEF-1:0] ALUC_LUI = 4'd5;
  localparam logic [ALUC_W_DEF-1:0] ALUC_SLL = 4'd6;
  localparam logic [ALUC_W_DEF-1:0] ALUC_SRL = 4'd7;
  localparam logic [ALUC_W_DEF-1:0] ALUC_SRA = 4'd8;

  typedef struct packed {
    logic                  valid;
    logic                  wreg;
    logic                  m2reg;
    logic                  wmem;
    logic                  aluimm;
    logic [ALUC_W_DEF-1:0] aluc;
  } idexe_ctrl_t;

  localparam idexe_ctrl_t CTRL_NOP = '0;

  // A bubble keeps nothing that could write state.
  function automatic idexe_ctrl_t kill(idexe_ctrl_t c);
    idexe_ctrl_t r;
    r       = c;
    r.valid = 1'b0;
    r.wreg  = 1'b0;
    r.m2reg = 1'b0;
    r.wmem  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/idexe_pipe_reg_if.sv
// Decode-to-execute bundle: decoded fields in, registered fields out,
// plus the stall/flush controls and the front-end hold request.
interface idexe_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
);
  logic              stall;
  logic              flush;
  logic              dvalid;
  logic              dwreg;
  logic              dm2reg;
  logic              dwmem;
  logic              daluimm;
  logic [ALUC_W-1:0] daluc;
  logic [REG_AW-1:0] ddestReg;
  logic [REG_AW-1:0] drs;
  logic [REG_AW-1:0] drt;
  logic              duse_rs;
  logic              duse_rt;
  logic [XLEN-1:0]   dqa;
  logic [XLEN-1:0]   dqb;
  logic [XLEN-1:0]   dimm32;

  logic              evalid;
  logic              ewreg;
  logic              em2reg;
  logic              ewmem;
  logic              ealuimm;
  logic [ALUC_W-1:0] ealuc;
  logic [REG_AW-1:0] edestReg;
  logic [XLEN-1:0]   eqa;
  logic [XLEN-1:0]   eqb;
  logic [XLEN-1:0]   eimm32;
  logic              hold_front;

  modport master (
    output stall, flush, dvalid, dwreg, dm2reg, dwmem,
    output daluimm, daluc, ddestReg, drs, drt,
    output duse_rs, duse_rt, dqa, dqb, dimm32,
    input  evalid, ewreg, em2reg, ewmem, ealuimm,
    input  ealuc, edestReg, eqa, eqb, eimm32,
    input  hold_front
  );

  modport slave (
    input  stall, flush, dvalid, dwreg, dm2reg, dwmem,
    input  daluimm, daluc, ddestReg, drs, drt,
    input  duse_rs, duse_rt, dqa, dqb, dimm32,
    output evalid, ewreg, em2reg, ewmem, ealuimm,
    output ealuc, edestReg, eqa, eqb, eimm32,
    output hold_front
  );

endinterface

// File: rtl/hazard_unit.sv
// Load-use detector: a load in EXE whose result the decoding
// instruction reads. $0 is never a hazard.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              i_evalid,
  input  logic              i_em2reg,
  input  logic [REG_AW-1:0] i_edest,
  input  logic              i_dvalid,
  input  logic              i_duse_rs,
  input  logic [REG_AW-1:0] i_drs,
  input  logic              i_duse_rt,
  input  logic [REG_AW-1:0] i_drt,
  output logic              o_load_use
);

  logic w_eload;
  logic w_hit_rs;
  logic w_hit_rt;

  assign w_eload  = i_evalid & i_em2reg & (i_edest != '0);
  assign w_hit_rs = i_duse_rs & (i_drs == i_edest);
  assign w_hit_rt = i_duse_rt & (i_drt == i_edest);

  assign o_load_use = w_eload & (w_hit_rs | w_hit_rt) & i_dvalid;

endmodule

// File: rtl/idexe_pipe_reg.sv
// ID/EXE pipeline register with flush, stall and load-use bubbling.
// Define IDEXE_PERF_EN to add the stall_cnt/bubble_cnt counters.
module idexe_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int ALUC_W = ALUC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  idexe_pipe_reg_if.slave  bus
`ifdef IDEXE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  idexe_ctrl_t       r_ctrl;
  logic [REG_AW-1:0] r_dest;
  logic [XLEN-1:0]   r_qa;
  logic [XLEN-1:0]   r_qb;
  logic [XLEN-1:0]   r_imm;

  idexe_ctrl_t       w_dctrl;
  logic              w_load_use;
  logic              w_hold;
  logic              w_bubble;

  hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .i_evalid   (r_ctrl.valid),
    .i_em2reg   (r_ctrl.m2reg),
    .i_edest    (r_dest),
    .i_dvalid   (bus.dvalid),
    .i_duse_rs  (bus.duse_rs),
    .i_drs      (bus.drs),
    .i_duse_rt  (bus.duse_rt),
    .i_drt      (bus.drt),
    .o_load_use (w_load_use)
  );

  // flush beats stall, stall beats load-use
  assign w_hold   = bus.stall & ~bus.flush;
  assign w_bubble = bus.flush | (w_load_use & ~bus.stall);

  always_comb begin
    w_dctrl        = CTRL_NOP;
    w_dctrl.valid  = bus.dvalid;
    w_dctrl.wreg   = bus.dwreg & bus.dvalid;
    w_dctrl.m2reg  = bus.dm2reg & bus.dvalid;
    w_dctrl.wmem   = bus.dwmem & bus.dvalid;
    w_dctrl.aluimm = bus.daluimm;
    w_dctrl.aluc   = ALUC_W_DEF'(bus.daluc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= CTRL_NOP;
      r_dest <= '0;
      r_qa   <= '0;
      r_qb   <= '0;
      r_imm  <= '0;
    end else if (!w_hold) begin
      r_ctrl <= w_bubble ? kill(w_dctrl) : w_dctrl;
      r_dest <= bus.ddestReg;
      r_qa   <= bus.dqa;
      r_qb   <= bus.dqb;
      r_imm  <= bus.dimm32;
    end
  end

  assign bus.evalid     = r_ctrl.valid;
  assign bus.ewreg      = r_ctrl.wreg;
  assign bus.em2reg     = r_ctrl.m2reg;
  assign bus.ewmem      = r_ctrl.wmem;
  assign bus.ealuimm    = r_ctrl.aluimm;
  assign bus.ealuc      = ALUC_W'(r_ctrl.aluc);
  assign bus.edestReg   = r_dest;
  assign bus.eqa        = r_qa;
  assign bus.eqb        = r_qb;
  assign bus.eimm32     = r_imm;
  assign bus.hold_front = bus.stall | (w_load_use & ~bus.flush);

`ifdef IDEXE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (bus.stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble)  r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Directed bench for idexe_pipe_reg; counter checks are built
// only when IDEXE_PERF_EN is defined.
module tb_idexe_pipe_reg;
  import mips_pipe_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  idexe_pipe_reg_if #(.XLEN(32), .REG_AW(5), .ALUC_W(4)) bus ();

`ifdef IDEXE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  idexe_pipe_reg #(
    .XLEN(32), .REG_AW(5), .ALUC_W(4), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef IDEXE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_dec;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.dvalid   = 1'b0;
    bus.dwreg    = 1'b0;
    bus.dm2reg   = 1'b0;
    bus.dwmem    = 1'b0;
    bus.daluimm  = 1'b0;
    bus.daluc    = '0;
    bus.ddestReg = '0;
    bus.drs      = '0;
    bus.drt      = '0;
    bus.duse_rs  = 1'b0;
    bus.duse_rt  = 1'b0;
    bus.dqa      = '0;
    bus.dqb      = '0;
    bus.dimm32   = '0;
  endtask

  task automatic dec_instr(
    input logic [4:0]  dest,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic        use_rs,
    input logic        use_rt,
    input logic        m2reg,
    input logic [31:0] qa
  );
    bus.dvalid   = 1'b1;
    bus.dwreg    = 1'b1;
    bus.dm2reg   = m2reg;
    bus.dwmem    = 1'b0;
    bus.daluimm  = m2reg;
    bus.daluc    = ALUC_ADD;
    bus.ddestReg = dest;
    bus.drs      = rs;
    bus.drt      = rt;
    bus.duse_rs  = use_rs;
    bus.duse_rt  = use_rt;
    bus.dqa      = qa;
    bus.dqb      = 32'h0000_00B0;
    bus.dimm32   = m2reg ? 32'h10 : 32'h0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_dec();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dec_instr(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 32'hCAFE_0001);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();
    checks++;
    if ({bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem,
         bus.ealuimm} !== 5'b0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=00000",
        {bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem,
         bus.ealuimm});
    end
    checks++;
    if ({bus.ealuc, bus.edestReg} !== 9'b0) begin
      failures++;
      $display("FAIL rst_aluc_dest got=%h exp=0",
        {bus.ealuc, bus.edestReg});
    end
    checks++;
    if ({bus.eqa, bus.eqb, bus.eimm32} !== 96'b0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0",
        {bus.eqa, bus.eqb, bus.eimm32});
    end
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold got=%b exp=0", bus.hold_front);
    end
`ifdef IDEXE_PERF_EN
    checks++;
    if ({stall_cnt, bubble_cnt} !== 8'h00) begin
      failures++;
      $display("FAIL rst_cnt got=%h exp=00",
        {stall_cnt, bubble_cnt});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_load;
    idle_dec();
    bus.dvalid   = 1'b1;
    bus.dwreg    = 1'b1;
    bus.dwmem    = 1'b1;
    bus.daluimm  = 1'b1;
    bus.daluc    = ALUC_SUB;
    bus.ddestReg = 5'd9;
    bus.dqa      = 32'hAAAA_0001;
    bus.dqb      = 32'hBBBB_0002;
    bus.dimm32   = 32'hFFFF_FFFC;
    tick();
    checks++;
    if ({bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem,
         bus.ealuimm} !== 5'b11011) begin
      failures++;
      $display("FAIL load_ctrl got=%b exp=11011",
        {bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem,
         bus.ealuimm});
    end
    checks++;
    if (bus.ealuc !== ALUC_SUB || bus.edestReg !== 5'd9) begin
      failures++;
      $display("FAIL load_aluc_dest got=%h/%0d exp=1/9",
        bus.ealuc, bus.edestReg);
    end
    checks++;
    if (bus.eqa !== 32'hAAAA_0001 || bus.eqb !== 32'hBBBB_0002
        || bus.eimm32 !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL load_data got=%h %h %h exp=aaaa0001 bbbb0002 fffffffc",
        bus.eqa, bus.eqb, bus.eimm32);
    end
    bus.dvalid = 1'b0;
    bus.dm2reg = 1'b1;
    #1;
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL load_hold got=%b exp=0", bus.hold_front);
    end
    tick();
    checks++;
    if ({bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem} !== 4'b0) begin
      failures++;
      $display("FAIL invalid_ctrl got=%b exp=0000",
        {bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem});
    end
  endtask

  task automatic test_load_use;
    idle_dec();
    dec_instr(5'd8, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    dec_instr(5'd9, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0, 32'h200);
    #1;
    checks++;
    if (bus.hold_front !== 1'b1) begin
      failures++;
      $display("FAIL lu_hold got=%b exp=1", bus.hold_front);
    end
    tick();
    checks++;
    if ({bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem} !== 4'b0) begin
      failures++;
      $display("FAIL lu_bubble got=%b exp=0000",
        {bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem});
    end
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL lu_hold_once got=%b exp=0", bus.hold_front);
    end
    tick();
    checks++;
    if (bus.evalid !== 1'b1 || bus.ewreg !== 1'b1
        || bus.edestReg !== 5'd9) begin
      failures++;
      $display("FAIL lu_add got=%b%b/%0d exp=11/9",
        bus.evalid, bus.ewreg, bus.edestReg);
    end
    dec_instr(5'd8, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    dec_instr(5'd11, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 32'h300);
    #1;
    checks++;
    if (bus.hold_front !== 1'b1) begin
      failures++;
      $display("FAIL lu_rt_hold got=%b exp=1", bus.hold_front);
    end
    bus.duse_rt = 1'b0;
    #1;
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL lu_rt_unused got=%b exp=0", bus.hold_front);
    end
    bus.duse_rt = 1'b1;
    bus.dvalid  = 1'b0;
    #1;
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL lu_dinvalid got=%b exp=0", bus.hold_front);
    end
    idle_dec();
    tick();
  endtask

  task automatic test_dest_zero;
    dec_instr(5'd0, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    dec_instr(5'd9, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h200);
    #1;
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL r0_hold got=%b exp=0", bus.hold_front);
    end
    tick();
    checks++;
    if (bus.evalid !== 1'b1 || bus.edestReg !== 5'd9) begin
      failures++;
      $display("FAIL r0_nobubble got=%b/%0d exp=1/9",
        bus.evalid, bus.edestReg);
    end
    idle_dec();
  endtask

  task automatic test_stall;
    do_reset();
    dec_instr(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h1234);
    tick();
    dec_instr(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'hDEAD);
    bus.stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.hold_front !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b exp=1",
          i, bus.hold_front);
      end
      tick();
      checks++;
      if (bus.eqa !== 32'h1234 || bus.edestReg !== 5'd5) begin
        failures++;
        $display("FAIL stall_keep[%0d] got=%h/%0d exp=1234/5",
          i, bus.eqa, bus.edestReg);
      end
    end
    bus.stall = 1'b0;
`ifdef IDEXE_PERF_EN
    checks++;
    if (stall_cnt !== 4'd3 || bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL stall_cnt got=%0d/%0d exp=3/0",
        stall_cnt, bubble_cnt);
    end
`endif
    tick();
    checks++;
    if (bus.eqa !== 32'hDEAD || bus.edestReg !== 5'd7) begin
      failures++;
      $display("FAIL stall_release got=%h/%0d exp=dead/7",
        bus.eqa, bus.edestReg);
    end
    idle_dec();
  endtask

  task automatic test_flush_stall;
    do_reset();
    dec_instr(5'd8, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    dec_instr(5'd9, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0, 32'h200);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.hold_front !== 1'b1) begin
      failures++;
      $display("FAIL fs_hold got=%b exp=1", bus.hold_front);
    end
    tick();
    checks++;
    if ({bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem} !== 4'b0) begin
      failures++;
      $display("FAIL fs_bubble got=%b exp=0000",
        {bus.evalid, bus.ewreg, bus.em2reg, bus.ewmem});
    end
`ifdef IDEXE_PERF_EN
    checks++;
    if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL fs_cnt got=%0d/%0d exp=1/1",
        stall_cnt, bubble_cnt);
    end
`endif
    bus.stall = 1'b0;
    #1;
    checks++;
    if (bus.hold_front !== 1'b0) begin
      failures++;
      $display("FAIL flush_nohold got=%b exp=0", bus.hold_front);
    end
    tick();
    checks++;
    if (bus.evalid !== 1'b0 || bus.ewreg !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble got=%b%b exp=00",
        bus.evalid, bus.ewreg);
    end
`ifdef IDEXE_PERF_EN
    checks++;
    if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd2) begin
      failures++;
      $display("FAIL flush_cnt got=%0d/%0d exp=1/2",
        stall_cnt, bubble_cnt);
    end
`endif
    bus.flush = 1'b0;
    tick();
    checks++;
    if (bus.evalid !== 1'b1 || bus.edestReg !== 5'd9) begin
      failures++;
      $display("FAIL flush_resume got=%b/%0d exp=1/9",
        bus.evalid, bus.edestReg);
    end
    idle_dec();
  endtask

`ifdef IDEXE_PERF_EN
  task automatic test_wrap;
    do_reset();
    bus.stall = 1'b1;
    repeat (16) tick();
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap16 got=%0d exp=0", stall_cnt);
    end
    tick();
    bus.stall = 1'b0;
    checks++;
    if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap17 got=%0d/%0d exp=1/0",
        stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_dec();
    test_reset();
    test_load();
    test_load_use();
    test_dest_zero();
    test_stall();
    test_flush_stall();
`ifdef IDEXE_PERF_EN
    test_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
